// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared encodings for the multi-cycle RV32 subset control FSM
//
// Purpose: opcode constants, ALU operation codes, ALU source mux encodings
//          and the 4-bit state encoding used by multicycle_control and its
//          datapath neighbours.
// Ports:   none (package)
package multicycle_control_pkg;

    // Supported opcodes (IR[6:0])
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // alu_op codes consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operand A mux
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU operand B mux
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // FSM state encoding; IDLE must stay at zero so a cleared register is safe
    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_FETCH     = 4'd1;
    localparam state_t ST_DECODE    = 4'd2;
    localparam state_t ST_EXEC_R    = 4'd3;
    localparam state_t ST_EXEC_I    = 4'd4;
    localparam state_t ST_ALU_WB    = 4'd5;
    localparam state_t ST_MEM_ADDR  = 4'd6;
    localparam state_t ST_MEM_READ  = 4'd7;
    localparam state_t ST_MEM_WB    = 4'd8;
    localparam state_t ST_MEM_WRITE = 4'd9;
    localparam state_t ST_BRANCH    = 4'd10;

    // DECODE dispatch: first state of the execute phase, or FETCH when the
    // opcode is not part of the supported subset.
    function automatic state_t decode_dispatch(input logic [6:0] opc);
        state_t nxt;
        case (opc)
            OPC_RTYPE:            nxt = ST_EXEC_R;
            OPC_ITYPE:            nxt = ST_EXEC_I;
            OPC_LOAD, OPC_STORE:  nxt = ST_MEM_ADDR;
            OPC_BRANCH:           nxt = ST_BRANCH;
            default:              nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multi-cycle RV32 subset datapath
//
// Purpose: sequences shared ALU, unified memory, IR and register file over
//          3-5 cycles per instruction (R-type, addi, lw, sw, beq).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   opcode[6:0]                IR[6:0], sampled in DECODE and MEM_ADDR only
//   mem_ready                  memory access completes this cycle
//   pc_write, pc_write_cond    unconditional / zero-conditional PC load
//   pc_source                  0=ALU result, 1=ALUOut
//   i_or_d                     memory address: 0=PC, 1=ALUOut
//   mem_read, mem_write        memory requests (never both)
//   ir_write                   IR load
//   mem_to_reg, reg_write      writeback source and enable
//   alu_src_a[1:0]             00=PC, 01=reg A, 10=old PC
//   alu_src_b[1:0]             00=reg B, 01=4, 10=imm
//   alu_op[1:0]                00=add, 01=sub, 10=funct
//   instr_done                 pulse in the final state of each legal instruction
//   illegal_op                 pulse in DECODE for an unsupported opcode
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state_q;
    state_t state_d;

    // Asynchronous reset clears the state at once; since every output is
    // decoded from state_q, an in-flight memory request drops immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:      state_d = ST_FETCH;
            ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE:    state_d = decode_dispatch(opcode);
            ST_EXEC_R:    state_d = ST_ALU_WB;
            ST_EXEC_I:    state_d = ST_ALU_WB;
            ST_ALU_WB:    state_d = ST_FETCH;
            ST_MEM_ADDR: begin
                // The IR still holds lw or sw here; anything else means the
                // IR was disturbed, so restart cleanly from IDLE.
                if (opcode == OPC_LOAD) begin
                    state_d = ST_MEM_READ;
                end else if (opcode == OPC_STORE) begin
                    state_d = ST_MEM_WRITE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_READ:  state_d = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_d = ST_FETCH;
            ST_MEM_WRITE: state_d = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_BRANCH:    state_d = ST_FETCH;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output decode (Moore plus mem_ready qualification)
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // PC+4 is computed every FETCH cycle but only committed,
                // together with the IR load, when the read returns.
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // Speculative branch target (old PC + imm) lands in ALUOut.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                illegal_op = (decode_dispatch(opcode) == ST_FETCH);
            end
            ST_EXEC_R: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_REG;
                alu_op    = ALUOP_FUNCT;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            ST_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            ST_BRANCH: begin
                // rs1 - rs2 sets zero; PC takes the DECODE target from ALUOut.
                alu_src_a     = SRCA_REG;
                alu_src_b     = SRCB_REG;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                instr_done    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_source, i_or_d;
    logic       mem_read, mem_write, ir_write, mem_to_reg, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic       instr_done, illegal_op;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: every output gathered in a fixed order so one compare
    // covers the whole set.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    ctrl_t act;
    assign act = '{pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                   ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                   instr_done, illegal_op};

    // Instruction phases as named in the datapath description.
    typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_DECODE_BAD, P_EXEC_R, P_EXEC_I,
                      P_ALU_WB, P_MEM_ADDR, P_MEM_READ, P_MEM_WB, P_MEM_WRITE,
                      P_BRANCH} phase_t;

    // Reference: required control outputs for a phase given mem_ready.
    function automatic ctrl_t model(input phase_t p, input logic rdy);
        ctrl_t c;
        c = '0;
        case (p)
            P_FETCH: begin
                c.mem_read = 1'b1; c.alu_src_b = 2'b01;
                c.ir_write = rdy;  c.pc_write  = rdy;
            end
            P_DECODE:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
            P_DECODE_BAD: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; c.illegal_op = 1'b1; end
            P_EXEC_R:     begin c.alu_src_a = 2'b01; c.alu_op = 2'b10; end
            P_EXEC_I:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            P_MEM_ADDR:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            P_ALU_WB:     begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            P_MEM_READ:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            P_MEM_WB:     begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
            P_MEM_WRITE:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = rdy; end
            P_BRANCH: begin
                c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                c.pc_source = 1'b1;  c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input ctrl_t exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, compare at the falling edge, then
    // return just after the next rising edge.
    task automatic cyc(input logic rdy, input phase_t p, input string tag);
        mem_ready = rdy;
        @(negedge clk);
        check(tag, model(p, rdy));
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Builds the phase sequence of one instruction from its opcode and the
    // memory wait counts, and checks every cycle of it.
    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input string tag);
        opcode = opc;
        for (int i = 0; i < fw; i++) cyc(1'b0, P_FETCH, {tag, "_fetch_wait"});
        cyc(1'b1, P_FETCH, {tag, "_fetch"});
        case (opc)
            7'b0110011: begin
                cyc(rnd_bit(), P_DECODE, {tag, "_decode"});
                cyc(rnd_bit(), P_EXEC_R, {tag, "_exec_r"});
                cyc(rnd_bit(), P_ALU_WB, {tag, "_alu_wb"});
            end
            7'b0010011: begin
                cyc(rnd_bit(), P_DECODE, {tag, "_decode"});
                cyc(rnd_bit(), P_EXEC_I, {tag, "_exec_i"});
                cyc(rnd_bit(), P_ALU_WB, {tag, "_alu_wb"});
            end
            7'b0000011: begin
                cyc(rnd_bit(), P_DECODE, {tag, "_decode"});
                cyc(rnd_bit(), P_MEM_ADDR, {tag, "_mem_addr"});
                for (int i = 0; i < mw; i++) cyc(1'b0, P_MEM_READ, {tag, "_mem_read_wait"});
                cyc(1'b1, P_MEM_READ, {tag, "_mem_read"});
                cyc(rnd_bit(), P_MEM_WB, {tag, "_mem_wb"});
            end
            7'b0100011: begin
                cyc(rnd_bit(), P_DECODE, {tag, "_decode"});
                cyc(rnd_bit(), P_MEM_ADDR, {tag, "_mem_addr"});
                for (int i = 0; i < mw; i++) cyc(1'b0, P_MEM_WRITE, {tag, "_mem_write_wait"});
                cyc(1'b1, P_MEM_WRITE, {tag, "_mem_write"});
            end
            7'b1100011: begin
                cyc(rnd_bit(), P_DECODE, {tag, "_decode"});
                cyc(rnd_bit(), P_BRANCH, {tag, "_branch"});
            end
            default: cyc(rnd_bit(), P_DECODE_BAD, {tag, "_decode_illegal"});
        endcase
    endtask

    logic [6:0] opc_tab [6];

    initial begin
        opc_tab[0] = 7'b0110011;
        opc_tab[1] = 7'b0010011;
        opc_tab[2] = 7'b0000011;
        opc_tab[3] = 7'b0100011;
        opc_tab[4] = 7'b1100011;
        opc_tab[5] = 7'b1111111;

        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = 7'b0;
        @(posedge clk);
        #1;
        check("reset_idle", model(P_IDLE, 1'b0));
        reset = 1'b0;
        cyc(1'b1, P_IDLE, "idle_after_release");

        // add with memory always ready: F, D, EXEC_R, ALU_WB
        run_instr(7'b0110011, 0, 0, "add");
        // fetch stalled two cycles, then addi
        run_instr(7'b0010011, 2, 0, "addi_fetch_stall");
        // lw with three not-ready cycles in MEM_READ
        run_instr(7'b0000011, 0, 3, "lw_stall");
        run_instr(7'b0100011, 0, 2, "sw_stall");
        run_instr(7'b1100011, 0, 0, "beq");
        run_instr(7'b1111111, 0, 0, "illegal");
        run_instr(7'b0000011, 0, 0, "lw");

        // Reset while a load is waiting on memory
        opcode = 7'b0000011;
        cyc(1'b1, P_FETCH, "rst_fetch");
        cyc(1'b0, P_DECODE, "rst_decode");
        cyc(1'b0, P_MEM_ADDR, "rst_mem_addr");
        mem_ready = 1'b0;
        #1;
        check("rst_pre_read", model(P_MEM_READ, 1'b0));
        reset = 1'b1;
        #1;
        check("reset_mid_access", model(P_IDLE, 1'b0));
        @(posedge clk);
        #1;
        check("reset_held", model(P_IDLE, 1'b0));
        reset = 1'b0;
        cyc(1'b0, P_IDLE, "idle_after_mid_reset");
        cyc(1'b0, P_FETCH, "fetch_after_reset_wait");

        // Randomised instruction mix
        for (int n = 0; n < 60; n++) begin
            int k;
            k = int'($urandom_range(0, 5));
            run_instr(opc_tab[k], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      $sformatf("rand%0d_k%0d", n, k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
